// File: rtl/digest_update_ctrl.sv
// Final SHA-256 hash-state update: H[i] += W[i] for i = 0..NWORDS-1, one word per
// cycle through an external shared adder. Holds the digest registers H0..H7.
module digest_update_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NWORDS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_init,
  input  logic                      i_start,
  input  logic [WIDTH*NWORDS-1:0]   i_work,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [WIDTH*NWORDS-1:0]   o_digest,
  output logic                      o_add_en,
  output logic [WIDTH-1:0]          o_add_a,
  output logic [WIDTH-1:0]          o_add_b,
  input  logic [WIDTH-1:0]          i_add_summ
);

  localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned DigW = WIDTH * NWORDS;

  // SHA-256 initial hash value, H0 in the least significant word.
  localparam logic [DigW-1:0] Iv = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DigW-1:0]   h_q, h_d;
  logic [DigW-1:0]   w_q, w_d;

  // State, index, digest and working-variable registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      h_q     <= Iv;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
      w_q     <= w_d;
    end
  end

  // Next-state logic and decoded adder/handshake outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    h_d      = h_q;
    w_d      = w_q;
    o_done   = 1'b0;
    o_add_en = 1'b0;
    o_add_a  = '0;
    o_add_b  = '0;

    case (state_q)
      StIdle: begin
        // init has priority; a coincident start is dropped.
        if (i_init) begin
          h_d = Iv;
        end else if (i_start) begin
          w_d     = i_work;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        o_add_en = 1'b1;
        o_add_a  = h_q[idx_q*WIDTH +: WIDTH];
        o_add_b  = w_q[idx_q*WIDTH +: WIDTH];
        h_d[idx_q*WIDTH +: WIDTH] = i_add_summ;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_busy   = (state_q != StIdle);
  assign o_digest = h_q;

endmodule

// File: tb/tb_digest_update_ctrl.sv
// Self-checking bench for digest_update_ctrl: table of work vectors with hand
// expectations, a scoreboard of expected digests popped on o_done, and
// hand-written sequences for disturbance and mid-update reset.
module tb_digest_update_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NWORDS = 8;
  localparam int unsigned DigW   = WIDTH * NWORDS;

  logic              clk;
  logic              rst;
  logic              init;
  logic              start;
  logic [DigW-1:0]   work;
  logic              busy;
  logic              done;
  logic [DigW-1:0]   digest;
  logic              add_en;
  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_summ;

  int n_checks;
  int n_fail;

  logic [DigW-1:0] iv;
  logic [DigW-1:0] h_model;
  logic [DigW-1:0] exp_q[$];

  typedef struct {
    string           name;
    logic [DigW-1:0] work;
    logic [31:0]     exp_h0;
    logic [31:0]     exp_h7;
  } vec_t;

  vec_t vecs[5];

  digest_update_ctrl #(
    .WIDTH  (WIDTH),
    .NWORDS (NWORDS)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_init     (init),
    .i_start    (start),
    .i_work     (work),
    .o_busy     (busy),
    .o_done     (done),
    .o_digest   (digest),
    .o_add_en   (add_en),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .i_add_summ (add_summ)
  );

  // The external shared adder: carry-out discarded.
  assign add_summ = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [DigW-1:0] v, input int k);
    return v[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [DigW-1:0] add_words(input logic [DigW-1:0] h,
                                                input logic [DigW-1:0] w);
    logic [DigW-1:0] r;
    for (int k = 0; k < NWORDS; k++) begin
      r[k*WIDTH +: WIDTH] = h[k*WIDTH +: WIDTH] + w[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [DigW-1:0] act,
                       input logic [DigW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    h_model = iv;
    check("init_busy", DigW'(busy), DigW'(0));
    check("init_digest", digest, iv);
  endtask

  // One full update; when disturb is set, init/start are toggled during ADD and
  // start is held during DONE, none of which may change the outcome.
  task automatic run_update(input string name, input logic [DigW-1:0] w, input bit disturb);
    logic [DigW-1:0] exp;
    h_model = add_words(h_model, w);
    exp_q.push_back(h_model);
    work  = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) work = ~w;
    for (int k = 0; k < NWORDS; k++) begin
      check({name, "_add_en"}, DigW'(add_en), DigW'(1));
      check({name, "_busy"}, DigW'(busy), DigW'(1));
      check({name, "_no_done"}, DigW'(done), DigW'(0));
      check({name, "_add_b_order"}, DigW'(add_b), DigW'(word_of(w, k)));
      start = disturb && (k == 2 || k == 5);
      init  = disturb && (k == 3 || k == 6);
      tick();
    end
    init  = 1'b0;
    start = disturb;
    check({name, "_done"}, DigW'(done), DigW'(1));
    check({name, "_add_en_off"}, DigW'(add_en), DigW'(0));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_digest"}, digest, exp);
    end
    tick();
    start = 1'b0;
    check({name, "_done_pulse"}, DigW'(done), DigW'(0));
    check({name, "_idle"}, DigW'(busy), DigW'(0));
    tick();
    check({name, "_still_idle"}, DigW'(busy), DigW'(0));
    check({name, "_digest_hold"}, digest, h_model);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    logic [DigW-1:0] w;
    logic [DigW-1:0] w_undisturbed;

    n_checks = 0;
    n_fail   = 0;
    iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    h_model = iv;

    vecs[0] = '{"zeros", '0, 32'h6a09e667, 32'h5be0cd19};
    vecs[1] = '{"ramp", {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                32'h6a09e668, 32'h5be0cd21};
    vecs[2] = '{"wrap_a", {224'h0, 32'hffffffff}, 32'h6a09e666, 32'h5be0cd19};
    vecs[3] = '{"all_ones", {DigW{1'b1}}, 32'h6a09e666, 32'h5be0cd18};
    vecs[4] = '{"wrap_h_to_zero", {32'ha41f32e7, 224'h0}, 32'h6a09e667, 32'h00000000};

    rst   = 1'b1;
    init  = 1'b0;
    start = 1'b0;
    work  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    check("reset_digest", digest, iv);
    check("reset_busy", DigW'(busy), DigW'(0));
    check("reset_done", DigW'(done), DigW'(0));
    check("reset_add_en", DigW'(add_en), DigW'(0));
    check("reset_add_a", DigW'(add_a), DigW'(0));
    check("reset_add_b", DigW'(add_b), DigW'(0));

    for (int i = 0; i < 5; i++) begin
      do_init();
      run_update(vecs[i].name, vecs[i].work, 1'b0);
      check({vecs[i].name, "_h0"}, DigW'(word_of(digest, 0)), DigW'(vecs[i].exp_h0));
      check({vecs[i].name, "_h7"}, DigW'(word_of(digest, 7)), DigW'(vecs[i].exp_h7));
    end

    // Back-to-back updates without init accumulate into H.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NWORDS; k++) w[k*WIDTH +: WIDTH] = $urandom;
      run_update("chain", w, 1'b0);
    end

    // Disturbed run must match an undisturbed one on the same data.
    for (int k = 0; k < NWORDS; k++) w_undisturbed[k*WIDTH +: WIDTH] = $urandom;
    do_init();
    run_update("undisturbed", w_undisturbed, 1'b0);
    do_init();
    run_update("disturbed", w_undisturbed, 1'b1);

    // Reset in the middle of ADD: immediate return to IDLE, no done.
    do_init();
    work  = {DigW{1'b1}};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    h_model = iv;
    check("abort_busy", DigW'(busy), DigW'(0));
    check("abort_add_en", DigW'(add_en), DigW'(0));
    check("abort_digest", digest, iv);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", DigW'(done_seen), DigW'(0));

    // init and start together: init only.
    work  = {8{32'h12345678}};
    init  = 1'b1;
    start = 1'b1;
    tick();
    init  = 1'b0;
    start = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) busy_seen++;
      tick();
    end
    check("init_wins_busy", DigW'(busy_seen), DigW'(0));
    check("init_wins_digest", digest, iv);

    // Still functional after the abort.
    run_update("after_abort", vecs[1].work, 1'b0);
    check("after_abort_h0", DigW'(word_of(digest, 0)), DigW'(32'h6a09e668));

    check("scoreboard_drained", DigW'(exp_q.size()), DigW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/digest_update_ctrl.md
Name: digest_update_ctrl

Overview:
- Sequences the final SHA-256 hash-state update (H[i] += working variable i, for i = 0..7) through a single shared 32-bit adder.
- Does one addition per cycle rather than instantiating eight adders.
- Sits between the round datapath, which supplies working variables a..h after round 64, and the message-block controller, which issues init/start and consumes done/digest.
- Holds the eight digest registers H0..H7.

Parameters:
- WIDTH, 32, word width in bits.
- NWORDS, 8, number of hash-state words; the index counter is $clog2(NWORDS) bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_init  input  1  load SHA-256 IV into H0..H7; honoured only in IDLE.
- i_start  input  1  begin hash update; honoured only in IDLE.
- i_work  input  WIDTH*NWORDS  working variables a..h; a in [31:0], h in [255:224]; sampled on the accepted-start edge.
- o_busy  output  1  high in ADD and DONE.
- o_done  output  1  one-cycle pulse when the update is complete.
- o_digest  output  WIDTH*NWORDS  H0..H7, packed like i_work; driven directly from registers.
- o_add_en  output  1  shared-adder operands valid.
- o_add_a  output  WIDTH  adder operand A (= H[idx]).
- o_add_b  output  WIDTH  adder operand B (= W[idx]).
- i_add_summ  input  WIDTH  adder result; combinational, same cycle as the operands. The carry-out is not used.

Behaviour:
- Reset (async, i_rst=1):
  - State = IDLE, idx = 0, W regs = 0.
  - H0..H7 = SHA-256 IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - o_busy = 0, o_done = 0, o_add_en = 0, o_add_a = 0, o_add_b = 0, o_digest = IV.
- States are IDLE, ADD and DONE.
- IDLE:
  - i_init=1 → H ← IV; remain in IDLE.
  - i_start=1 with i_init=0 → W ← i_work, idx ← 0, go to ADD.
  - i_init and i_start both high → init wins; start is dropped.
- ADD:
  - o_add_en = 1, o_add_a = H[idx], o_add_b = W[idx].
  - Each edge: H[idx] ← i_add_summ, idx ← idx+1.
  - On the edge where idx = NWORDS-1 → go to DONE and reset idx to 0.
- DONE: o_done = 1 for exactly one cycle; the next edge returns to IDLE.
- Outputs outside ADD: o_add_en = 0, o_add_a = 0, o_add_b = 0 (registered or decoded; must be 0 outside ADD).
- Latency:
  - Start accepted at edge 0.
  - ADD occupies the cycles after edges 0..7.
  - o_done is high in the cycle after edge 8.
  - o_digest holds the final value from the cycle o_done rises and stays stable until the next init/start.
- Arithmetic: modulo 2^WIDTH. Overflow wraps with no flag.
- Intermediate o_digest values are visible during ADD. Consumers sample only on o_done.
- i_start and i_init are ignored in ADD and DONE, with no queuing. A start asserted during the DONE cycle is lost; the requester must hold or re-issue it in IDLE.
- i_work changes after the accepted-start edge have no effect.
- Reset mid-operation returns to IDLE immediately with H = IV. No o_done is produced for the aborted update.
- o_busy = (state != IDLE).

Test Plan:
- Reset released, no stimulus → o_digest = IV words listed above; o_busy=0, o_done=0, o_add_en=0.
- i_start with i_work = all zeros → o_add_en high for 8 cycles, idx order 0..7; o_done pulses once 9 cycles after start; o_digest = IV unchanged.
- i_work word i = i+1 (a=1..h=8) → H0 = 6a09e668, H7 = 5be0cd21, and every word equals IV[i]+i+1.
- Wrap-around: i_work a = ffffffff, others 0 → H0 = 6a09e666 (carry discarded); other words equal IV.
- i_start and i_init pulsed during ADD, plus i_start during DONE → ignored; exactly one o_done; result identical to the undisturbed run.
- Reset asserted after 4 ADD cycles → async return to IDLE, o_digest = IV, no o_done. A following i_init+i_start in the same cycle performs init only (o_busy stays 0).
